// File: rtl/afc_audio_pkg.sv
// Shared audio-path types: sample width, channel modes, capture FSM states, saturating helpers.
// Helpers work on a wide signed intermediate and clamp to a caller-supplied width.
package afc_audio_pkg;

    localparam int SAMPLE_W = 24;
    localparam int CALC_W   = 64;

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_AVG   = 2'b10;
    localparam logic [1:0] MODE_DIFF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        MIX   = 2'd2,
        PUSH  = 2'd3
    } cap_state_e;

    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t sat_to_width(input calc_t x, input int w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int w);
        return sat_to_width(a + b, w);
    endfunction

    function automatic calc_t sat_sub(input calc_t a, input calc_t b, input int w);
        return sat_to_width(a - b, w);
    endfunction

    // Magnitude of the most negative code clamps to the most positive one.
    function automatic calc_t sat_abs(input calc_t a, input int w);
        return sat_to_width((a < 0) ? -a : a, w);
    endfunction

endpackage

// File: rtl/codec_rx_capture_if.sv
// Codec ADC capture bundle: ready level and sample pair in, valid/ready sample stream out.
// master = capture block, slave = codec wrapper / stream consumer side.
interface codec_rx_capture_if
    import afc_audio_pkg::*;
#(
    parameter int W = SAMPLE_W
);
    logic                codec_ready;
    logic signed [W-1:0] l_bus_out;
    logic signed [W-1:0] r_bus_out;
    logic        [W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;

    modport master (
        input  codec_ready, l_bus_out, r_bus_out, m_ready,
        output m_data, m_valid
    );

    modport slave (
        output codec_ready, l_bus_out, r_bus_out, m_ready,
        input  m_data, m_valid
    );
endinterface

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO with occupancy count.
// Latency: push visible at the output one edge later; empty output reads as zero.
// Backpressure: push accepted when not full or when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    assign do_push   = push_i & (~full_o | do_pop);
    assign level_o   = level_q;
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/codec_rx_capture.sv
// Captures codec ADC pairs on ready rising edges, mixes per mode, buffers and streams them; counts drops.
// Latency: 4 edges from strobe to m_valid with an empty FIFO. Backpressure: full FIFO drops the sample.
// Optional CODEC_RX_PEAK_HOLD_EN adds peak_abs, the largest pushed magnitude.
module codec_rx_capture
    import afc_audio_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    codec_rx_capture_if.master     bus,
    input  logic [1:0]             mode,
    input  logic                   enable,
    input  logic                   clear_stats,
    output logic [AW:0]            fifo_level,
    output logic                   overflow,
    output logic [15:0]            overflow_cnt
`ifdef CODEC_RX_PEAK_HOLD_EN
    ,
    output logic [W-1:0]           peak_abs
`endif
);
    cap_state_e          state_q, state_d;
    logic                codec_ready_q;
    logic signed [W-1:0] l_q, l_d;
    logic signed [W-1:0] r_q, r_d;
    logic signed [W-1:0] mix_q, mix_d;
    logic [1:0]          mode_q, mode_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         ovf_cnt_q, ovf_cnt_d;
    calc_t               l_ext, r_ext;
    logic [1:0]          ovf_events;
    logic [16:0]         cnt_sum;

    logic strobe, pop, push_req, full, empty, drop, missed, push_acc;

    assign strobe   = bus.codec_ready & ~codec_ready_q;
    assign pop      = bus.m_valid & bus.m_ready;
    assign push_req = (state_q == PUSH);
    assign drop     = push_req & full & ~pop;
    assign push_acc = push_req & ~drop;
    assign missed   = strobe & enable & (state_q != IDLE);
    assign bus.m_valid = ~empty;

    sample_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_req),
        .push_dat_i (mix_q),
        .pop_i      (pop),
        .pop_dat_o  (bus.m_data),
        .level_o    (fifo_level),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        mode_d  = mode_q;
        mix_d   = mix_q;
        l_ext   = calc_t'(l_q);
        r_ext   = calc_t'(r_q);
        case (state_q)
            IDLE: begin
                if (strobe & enable) begin
                    state_d = LATCH;
                    l_d     = bus.l_bus_out;
                    r_d     = bus.r_bus_out;
                    mode_d  = mode;
                end
            end
            LATCH: begin
                state_d = MIX;
                case (mode_q)
                    MODE_LEFT:  mix_d = l_q;
                    MODE_RIGHT: mix_d = r_q;
                    MODE_AVG:   mix_d = W'((l_ext + r_ext) >>> 1);
                    default:    mix_d = W'(sat_sub(l_ext, r_ext, W));
                endcase
            end
            MIX:     state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A drop and a missed strobe can coincide; each costs one sample. Events beat clear_stats.
    always_comb begin
        ovf_events = 2'(drop) + 2'(missed);
        cnt_sum    = '0;
        ovf_cnt_d  = clear_stats ? 16'd0 : ovf_cnt_q;
        overflow_d = clear_stats ? 1'b0 : overflow_q;
        if (ovf_events != 2'd0) begin
            cnt_sum    = {1'b0, ovf_cnt_d} + 17'(ovf_events);
            ovf_cnt_d  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            overflow_d = 1'b1;
        end
    end

    // codec_ready_q resets high so a level already high at release is not a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            codec_ready_q <= 1'b1;
            l_q           <= '0;
            r_q           <= '0;
            mix_q         <= '0;
            mode_q        <= MODE_LEFT;
            overflow_q    <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            codec_ready_q <= bus.codec_ready;
            l_q           <= l_d;
            r_q           <= r_d;
            mix_q         <= mix_d;
            mode_q        <= mode_d;
            overflow_q    <= overflow_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    assign overflow     = overflow_q;
    assign overflow_cnt = ovf_cnt_q;

`ifdef CODEC_RX_PEAK_HOLD_EN
    logic [W-1:0] peak_q, peak_d, push_mag;

    always_comb begin
        push_mag = W'(sat_abs(calc_t'(mix_q), W));
        peak_d   = clear_stats ? '0 : peak_q;
        if (push_acc && (push_mag > peak_d)) begin
            peak_d = push_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_abs = peak_q;
`else
    logic unused_push_acc;
    assign unused_push_acc = push_acc;
`endif
endmodule

// File: tb/tb_codec_rx_capture.sv
// Bench for codec_rx_capture: directed vector table, hand-written corner sequences, randomized run vs queue model.
`timescale 1ns/1ps
module tb_codec_rx_capture;
    import afc_audio_pkg::*;

    localparam int W     = 24;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    mode;
    logic          enable;
    logic          clear_stats;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [15:0]   overflow_cnt;
`ifdef CODEC_RX_PEAK_HOLD_EN
    logic [W-1:0]  peak_abs;
`endif

    int tests = 0;
    int fails = 0;

    codec_rx_capture_if #(.W(W)) bus ();

    codec_rx_capture #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .mode         (mode),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_cnt (overflow_cnt)
`ifdef CODEC_RX_PEAK_HOLD_EN
        ,
        .peak_abs     (peak_abs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [1:0]   m;
        logic [W-1:0] expd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expd);
        tests++;
        if (got !== expd) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one pair and wait until its FIFO write edge has passed.
    task automatic capture(input logic [W-1:0] l, input logic [W-1:0] r, input logic [1:0] m);
        bus.l_bus_out   = l;
        bus.r_bus_out   = r;
        mode            = m;
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Reference mix from the arithmetic rules, using plain integer math.
    function automatic logic [W-1:0] ref_mix(input logic [W-1:0] l, input logic [W-1:0] r,
                                             input logic [1:0] m);
        longint li, ri, s, q, hi, lo;
        li = longint'($signed(l));
        ri = longint'($signed(r));
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -hi - 1;
        case (m)
            2'd0: q = li;
            2'd1: q = ri;
            2'd2: begin
                s = li + ri;
                q = s / 2;
                if (s < 0 && (s % 2) != 0) q = q - 1;
            end
            default: begin
                q = li - ri;
                if (q > hi) q = hi;
                if (q < lo) q = lo;
            end
        endcase
        return q[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_sample();
        case ($urandom_range(3))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        logic [W-1:0] mq[$];
        logic [W-1:0] pend;
        int drops;
        int push_edge;
        int gap;
        bit pop_m;
        bit full_m;

        vecs[0] = '{24'h000123, 24'h7FFFFF, 2'b00, 24'h000123};
        vecs[1] = '{24'hFFFFFD, 24'h000000, 2'b10, 24'hFFFFFE};
        vecs[2] = '{24'h7FFFFF, 24'h800000, 2'b11, 24'h7FFFFF};
        vecs[3] = '{24'h000005, 24'h7FFFFF, 2'b01, 24'h7FFFFF};
        vecs[4] = '{24'h800000, 24'h000001, 2'b11, 24'h800000};
        vecs[5] = '{24'h800000, 24'h800000, 2'b10, 24'h800000};
        vecs[6] = '{24'h7FFFFF, 24'h7FFFFF, 2'b10, 24'h7FFFFF};
        vecs[7] = '{24'hFFFFFF, 24'h000000, 2'b10, 24'hFFFFFF};
        vecs[8] = '{24'h000010, 24'h000003, 2'b11, 24'h00000D};
        vecs[9] = '{24'h000003, 24'h000010, 2'b11, 24'hFFFFF3};

        reset_n         = 1'b0;
        bus.codec_ready = 1'b1;
        bus.l_bus_out   = '0;
        bus.r_bus_out   = '0;
        bus.m_ready     = 1'b0;
        mode            = 2'b00;
        enable          = 1'b1;
        clear_stats     = 1'b0;

        // Reset values, then codec_ready held high across release must not strobe.
        repeat (3) tick();
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cnt", overflow_cnt, 0);
        reset_n = 1'b1;
        repeat (10) tick();
        chk("held_ready_level", fifo_level, 0);
        chk("held_ready_cnt", overflow_cnt, 0);
        chk("held_ready_valid", bus.m_valid, 0);
        bus.codec_ready = 1'b0;
        tick();

        // Vector table: mix result and strobe-to-valid latency.
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.l_bus_out   = vecs[i].l;
            bus.r_bus_out   = vecs[i].r;
            mode            = vecs[i].m;
            bus.codec_ready = 1'b1;
            edges = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                edges++;
                bus.codec_ready = 1'b0;
                if (bus.m_valid) break;
            end
            chk($sformatf("vec%0d_latency", i), edges, 4);
            chk($sformatf("vec%0d_data", i), bus.m_data, vecs[i].expd);
            tick();
            chk($sformatf("vec%0d_level_after", i), fifo_level, 0);
        end

        // Ten strobes with no consumer: eight stored, two dropped, then drained in order.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            capture(W'(i + 1), 24'h0, 2'b00);
            repeat (4) tick();
        end
        chk("full_level", fifo_level, DEPTH);
        chk("full_overflow", overflow, 1);
        chk("full_cnt", overflow_cnt, 2);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), bus.m_data, i + 1);
            tick();
        end
        chk("drain_level", fifo_level, 0);
        bus.m_ready = 1'b0;

        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_cnt", overflow_cnt, 0);
        chk("clear_overflow", overflow, 0);

        // Full FIFO with a pop in the PUSH cycle accepts the sample.
        for (int i = 0; i < 8; i++) begin
            capture(W'(24'h100 + i), 24'h0, 2'b00);
            tick();
        end
        bus.l_bus_out   = 24'h108;
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        tick();
        tick();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("pushpop_level", fifo_level, DEPTH);
        chk("pushpop_cnt", overflow_cnt, 0);
        chk("pushpop_head", bus.m_data, 24'h101);

        // Drop, then a drop coinciding with clear_stats leaves the count at one.
        capture(24'h200, 24'h0, 2'b00);
        chk("drop_cnt", overflow_cnt, 1);
        tick();
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        tick();
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_vs_drop_cnt", overflow_cnt, 1);
        chk("clear_vs_drop_ovf", overflow, 1);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_alone_cnt", overflow_cnt, 0);

        // Strobe while busy is counted as missed; strobe with enable low is ignored.
        bus.m_ready = 1'b1;
        repeat (10) tick();
        bus.m_ready = 1'b0;
        bus.l_bus_out   = 24'h55;
        mode            = 2'b00;
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        tick();
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        repeat (3) tick();
        chk("missed_level", fifo_level, 1);
        chk("missed_cnt", overflow_cnt, 1);
        chk("missed_data", bus.m_data, 24'h55);
        enable = 1'b0;
        capture(24'h66, 24'h0, 2'b00);
        repeat (4) tick();
        enable = 1'b1;
        chk("disabled_level", fifo_level, 1);
        chk("disabled_cnt", overflow_cnt, 1);

        // Reset during a capture abandons the sample.
        clear_stats = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        clear_stats = 1'b0;
        tick();
        bus.m_ready = 1'b0;
        bus.codec_ready = 1'b1;
        tick();
        bus.codec_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", bus.m_valid, 0);

`ifdef CODEC_RX_PEAK_HOLD_EN
        bus.m_ready = 1'b1;
        chk("peak_rst", peak_abs, 0);
        capture(24'h000005, 24'h0, 2'b00);
        chk("peak_5", peak_abs, 5);
        capture(24'hFFFFF7, 24'h0, 2'b00);
        chk("peak_9", peak_abs, 9);
        capture(24'h800000, 24'h0, 2'b00);
        chk("peak_min", peak_abs, 24'h7FFFFF);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("peak_clear", peak_abs, 0);
        bus.m_ready = 1'b0;
`endif

        // Randomized run against a queue model of the stream.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n   = 1'b1;
        drops     = 0;
        push_edge = -1;
        gap       = 2;
        pend      = '0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_level", fifo_level, mq.size());
            if (mq.size() > 0) chk("rnd_data", bus.m_data, mq[0]);
            else               chk("rnd_valid", bus.m_valid, 0);

            bus.m_ready = ($urandom_range(99) < ((c < 1500) ? 60 : 15));
            enable      = ($urandom_range(9) != 0);
            if (bus.codec_ready) begin
                bus.codec_ready = 1'b0;
            end else if (gap == 0) begin
                bus.l_bus_out   = rnd_sample();
                bus.r_bus_out   = rnd_sample();
                mode            = 2'($urandom_range(3));
                bus.codec_ready = 1'b1;
                if (enable) begin
                    push_edge = c + 4;
                    pend      = ref_mix(bus.l_bus_out, bus.r_bus_out, mode);
                end
                gap = $urandom_range(10, 5);
            end else begin
                gap--;
            end

            @(posedge clk);
            pop_m  = (mq.size() > 0) && bus.m_ready;
            full_m = (mq.size() >= DEPTH);
            if (pop_m) void'(mq.pop_front());
            if (push_edge == c + 1) begin
                if (!full_m || pop_m) mq.push_back(pend);
                else                  drops++;
            end
            #1;
        end
        chk("rnd_cnt", overflow_cnt, drops);
        chk("rnd_overflow", overflow, (drops != 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
